// File: rtl/mdu_unit.sv
// Multiply/divide unit for the EX stage: fixed-latency signed/unsigned
// mult/div plus the architectural HI/LO registers and MTHI/MTLO writes.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        Abort,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        sgn_q, sgn_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        accept;

  // Result is formed from the latched operands and only written at commit.
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_div;
  logic [31:0] q_mag, r_mag, quo, rem;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) *
                  $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  assign a_neg = sgn_q & a_q[31];
  assign b_neg = sgn_q & b_q[31];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;
  assign b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / b_div;
  assign r_mag = a_mag % b_div;
  assign quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  assign accept = Start & ~Abort & ~busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (Op)
            3'd0, 3'd1: begin
              state_d = S_MUL;
              cnt_d   = 4'(MULT_CYCLES);
              busy_d  = 1'b1;
              sgn_d   = ~Op[0];
              a_d     = A;
              b_d     = B;
            end
            3'd2, 3'd3: begin
              state_d = S_DIV;
              cnt_d   = 4'(DIV_CYCLES);
              busy_d  = 1'b1;
              sgn_d   = ~Op[0];
              a_d     = A;
              b_d     = B;
            end
            3'd4: hi_d = A;
            3'd5: lo_d = A;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (state_q == S_MUL) begin
            {hi_d, lo_d} = sgn_q ? prod_s : prod_u;
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      sgn_q   <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
